// File: rtl/ccip_intr_pkg.sv
// Shared CCI-P c1 channel types and interrupt scheduler definitions.
// Provides t_intr_state, MAX_INTR_VEC and the ccip_mk_intr_req() packet helper.
package ccip_intr_pkg;

  localparam int MAX_INTR_VEC = 4;
  localparam int INTR_ID_W    = $clog2(MAX_INTR_VEC);

  typedef enum logic [1:0] {
    INTR_IDLE     = 2'd0,
    INTR_PENDING  = 2'd1,
    INTR_INFLIGHT = 2'd2
  } t_intr_state;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [11:0]  rsvd1;
    t_ccip_c1_req req_type;
    logic [61:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_ReqIntrHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    logic [7:0]   rsvd1;
    t_ccip_c1_rsp resp_type;
    logic [13:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_RspIntrHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  function automatic t_if_ccip_c1_Tx ccip_mk_intr_req(
    input logic [INTR_ID_W-1:0] id
  );
    t_ccip_c1_ReqIntrHdr h;
    t_if_ccip_c1_Tx      t;
    h          = '0;
    h.req_type = eREQ_INTR;
    h.id       = id;
    t          = '0;
    t.hdr      = t_ccip_c1_ReqMemHdr'(h);
    t.valid    = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/ccip_intr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr.
// Ports: req (N), ptr (PW) -> gnt (one-hot N), any.
module intr_rr_arbiter
  import ccip_intr_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ccip_intr_scheduler.sv
// Shares the CCI-P c1 Tx channel between user writes and NUM_VEC interrupts.
// Ports: Clk_400, SoftReset_n, cp2af_sRxPort, intr_req/enable, user_c1_tx/ready,
//   af2cp_c1_tx, intr_pending/inflight, spurious_ack, intr_timeout.
// Optional: define CCIP_INTR_TIMEOUT_EN for per-vector ack timeout + reissue.
module ccip_intr_scheduler
  import ccip_intr_pkg::*;
#(
  parameter int NUM_VEC     = 4,
  parameter int STARVE_MAX  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               Clk_400,
  input  logic               SoftReset_n,
  input  t_if_ccip_Rx        cp2af_sRxPort,
  input  logic [NUM_VEC-1:0] intr_req,
  input  logic [NUM_VEC-1:0] intr_enable,
  input  t_if_ccip_c1_Tx     user_c1_tx,
  output logic               user_c1_ready,
  output t_if_ccip_c1_Tx     af2cp_c1_tx,
  output logic [NUM_VEC-1:0] intr_pending,
  output logic [NUM_VEC-1:0] intr_inflight,
  output logic               spurious_ack,
  output logic [NUM_VEC-1:0] intr_timeout
);

  localparam int PW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  t_intr_state         st_q [NUM_VEC];
  t_intr_state         st_d [NUM_VEC];
  logic [NUM_VEC-1:0]  rearm_q, rearm_d;
  logic [PW-1:0]       ptr_q, ptr_nxt;
  logic [SW-1:0]       starve_q;

  logic [NUM_VEC-1:0]  cand, gnt, issue;
  logic [NUM_VEC-1:0]  ack_vec, tmo_fire;
  logic                any_cand, slot, intr_win, user_acc;
  logic [INTR_ID_W-1:0] win_id, ack_id;
  logic                ack_valid, spur_evt;
  t_ccip_c1_RspIntrHdr rsp_intr;
  logic                rx_unused;

  assign rx_unused = ^cp2af_sRxPort;

  always_comb
    for (int v = 0; v < NUM_VEC; v++) begin
      cand[v]          = (st_q[v] == INTR_PENDING) && intr_enable[v];
      intr_pending[v]  = (st_q[v] == INTR_PENDING);
      intr_inflight[v] = (st_q[v] == INTR_INFLIGHT);
    end

  intr_rr_arbiter #(.N(NUM_VEC), .PW(PW)) u_arb (
    .req (cand),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (any_cand)
  );

  always_comb begin
    win_id  = '0;
    ptr_nxt = ptr_q;
    for (int v = 0; v < NUM_VEC; v++)
      if (gnt[v]) begin
        win_id  = INTR_ID_W'(v);
        ptr_nxt = (v == NUM_VEC-1) ? '0 : PW'(v + 1);
      end
  end

  // User traffic wins the slot until a pending vector has waited STARVE_MAX
  assign slot     = !cp2af_sRxPort.c1TxAlmFull;
  assign intr_win = slot && any_cand &&
                    (!user_c1_tx.valid || starve_q == SW'(STARVE_MAX));
  assign user_c1_ready = SoftReset_n && slot && !intr_win;
  assign user_acc = user_c1_tx.valid && user_c1_ready;
  assign issue    = intr_win ? gnt : '0;

  assign rsp_intr  = t_ccip_c1_RspIntrHdr'(cp2af_sRxPort.c1.hdr);
  assign ack_id    = rsp_intr.id;
  assign ack_valid = cp2af_sRxPort.c1.rspValid &&
                     rsp_intr.resp_type == eRSP_INTR;

  always_comb
    for (int v = 0; v < NUM_VEC; v++)
      ack_vec[v] = ack_valid && (ack_id == INTR_ID_W'(v));

  // An ack naming no implemented vector is spurious as well
  assign spur_evt = (|(ack_vec & ~intr_inflight)) ||
                    (ack_valid && ack_vec == '0);

`ifdef CCIP_INTR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]      tcnt_q [NUM_VEC];
  logic [NUM_VEC-1:0] tflag_q;

  always_comb
    for (int v = 0; v < NUM_VEC; v++)
      tmo_fire[v] = intr_inflight[v] && !ack_vec[v] &&
                    tcnt_q[v] == TW'(TIMEOUT_CYC - 1);

  always_ff @(posedge Clk_400 or negedge SoftReset_n)
    if (!SoftReset_n) begin
      tflag_q <= '0;
      for (int v = 0; v < NUM_VEC; v++) tcnt_q[v] <= '0;
    end else begin
      tflag_q <= tflag_q | tmo_fire;
      for (int v = 0; v < NUM_VEC; v++)
        if (st_q[v] == INTR_INFLIGHT && st_d[v] == INTR_INFLIGHT)
          tcnt_q[v] <= tcnt_q[v] + TW'(1);
        else
          tcnt_q[v] <= '0;
    end

  assign intr_timeout = tflag_q;
`else
  logic [31:0] tmo_unused;
  assign tmo_unused   = TIMEOUT_CYC;
  assign tmo_fire     = '0;
  assign intr_timeout = '0;
`endif

  always_comb
    for (int v = 0; v < NUM_VEC; v++) begin
      st_d[v]    = st_q[v];
      rearm_d[v] = rearm_q[v];
      unique case (st_q[v])
        INTR_IDLE:
          if (intr_req[v]) st_d[v] = INTR_PENDING;
        INTR_PENDING:
          if (issue[v]) begin
            st_d[v]    = INTR_INFLIGHT;
            rearm_d[v] = intr_req[v];
          end
        INTR_INFLIGHT:
          if (ack_vec[v]) begin
            st_d[v]    = (intr_req[v] || rearm_q[v]) ?
                         INTR_PENDING : INTR_IDLE;
            rearm_d[v] = 1'b0;
          end else if (tmo_fire[v]) begin
            st_d[v]    = INTR_PENDING;
            rearm_d[v] = 1'b0;
          end else if (intr_req[v]) begin
            rearm_d[v] = 1'b1;
          end
        default: begin
          st_d[v]    = INTR_IDLE;
          rearm_d[v] = 1'b0;
        end
      endcase
    end

  always_ff @(posedge Clk_400 or negedge SoftReset_n)
    if (!SoftReset_n) begin
      for (int v = 0; v < NUM_VEC; v++) st_q[v] <= INTR_IDLE;
      rearm_q      <= '0;
      ptr_q        <= '0;
      starve_q     <= '0;
      spurious_ack <= 1'b0;
      af2cp_c1_tx  <= '0;
    end else begin
      for (int v = 0; v < NUM_VEC; v++) st_q[v] <= st_d[v];
      rearm_q <= rearm_d;
      if (intr_win) ptr_q <= ptr_nxt;
      if (intr_win || !any_cand)
        starve_q <= '0;
      else if (user_acc && starve_q != SW'(STARVE_MAX))
        starve_q <= starve_q + SW'(1);
      if (spur_evt) spurious_ack <= 1'b1;
      unique case (1'b1)
        intr_win: af2cp_c1_tx <= ccip_mk_intr_req(win_id);
        user_acc: af2cp_c1_tx <= user_c1_tx;
        default:  af2cp_c1_tx <= '0;
      endcase
    end

endmodule
